// File: rtl/adder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adder_pkg : shared types and sizing helpers for multicycle_adder |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = nchunk(width, chunk);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | chunk_adder : combinational ripple adder of one_bit_adder cells  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    one_bit_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout = w_c[CHUNK];
  // Carry into the chunk MSB; only meaningful for the top chunk (overflow).
  assign cmsb = w_c[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/multicycle_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_adder : add/sub of WIDTH bits, CHUNK bits per cycle   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int c_NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int c_KW     = cnt_width(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t             r_state, w_next;
  logic [c_KW-1:0]    r_k;
  logic [WIDTH-1:0]   r_a, r_b, r_s;
  logic               r_c, r_cout, r_ovf;
  logic               w_load, w_last;
  logic [CHUNK-1:0]   w_sum;
  logic               w_co, w_cmsb;

  assign w_last = (r_k == c_KW'(c_NCHUNK - 1));

  // One adder slice, time-multiplexed across chunks by r_k.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (r_a[r_k*CHUNK +: CHUNK]),
    .b    (r_b[r_k*CHUNK +: CHUNK]),
    .cin  (r_c),
    .s    (w_sum),
    .cout (w_co),
    .cmsb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = BUSY;
        end
      end
      BUSY: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          w_load = in_valid;
          w_next = in_valid ? BUSY : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // Never advertise readiness while reset is asserted.
    if (rst) begin
      in_ready = 1'b0;
      w_load   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_a <= a;
      r_b <= sub ? ~b : b;
      r_c <= cin ^ sub;
      r_k <= '0;
    end else if (r_state == BUSY) begin
      r_s[r_k*CHUNK +: CHUNK] <= w_sum;
      r_c <= w_co;
      r_k <= w_last ? '0 : r_k + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= w_cmsb ^ w_co;
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule
`default_nettype wire

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  operand set presented.
REQ-006 Port in_ready  output  1  block can accept an operand set.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in (borrow-in when sub=1).
REQ-010 Port sub  input  1  0 = add, 1 = subtract.
REQ-011 Port out_valid  output  1  result held on s/cout/ovf.
REQ-012 Port out_ready  input  1  consumer takes result.
REQ-013 Port s  output  WIDTH  sum/difference.
REQ-014 Port cout  output  1  carry out of the MSB (1 = no borrow when sub=1).
REQ-015 Port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Arithmetic: b_eff = sub ? ~b : b; carry_0 = cin XOR sub; {cout, s} = a + b_eff + carry_0, computed modulo 2^WIDTH with the carry out of the MSB captured in cout.
REQ-017 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-018 The FSM has states IDLE, BUSY and DONE; counter k counts 0..NCHUNK-1, where NCHUNK = WIDTH/CHUNK.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch a, b_eff and carry_0, set k=0, and go to BUSY.
REQ-020 BUSY: each cycle, add chunk k of the latched operands using the registered carry; store the result into s[k*CHUNK +: CHUNK]; register the chunk carry-out; increment k.
REQ-021 BUSY exit: the cycle processing k=NCHUNK-1 SHALL also register cout and ovf and go to DONE.
REQ-022 Latency: with the input handshake at edge T, out_valid SHALL rise after edge T+NCHUNK.
REQ-023 DONE: out_valid=1; s, cout and ovf SHALL be held stable until out_valid&&out_ready.
REQ-024 in_ready SHALL be 0 in BUSY and in DONE when out_ready=0; in DONE, in_ready = out_ready (combinational).
REQ-025 Simultaneous events in DONE:
- out_ready=1 and in_valid=1: complete the output handshake, latch the new operands, and go directly to BUSY, with zero bubble.
- out_ready=1 and in_valid=0: go to IDLE.
REQ-026 in_valid during BUSY SHALL be ignored; latched operands SHALL NOT change.
REQ-027 out_valid SHALL be 0 in IDLE and BUSY; s, cout and ovf are undefined-but-stable outside DONE; s SHALL be updated only by BUSY writes.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, k=0, s=0, cout=0, ovf=0, out_valid=0, in_ready=0.
REQ-029 in_ready SHALL be 1 in the first cycle after rst is sampled low.
REQ-030 A reset in BUSY or DONE SHALL abandon the operation; no out_valid pulse SHALL follow for it.

Structure
REQ-031 A shared package adder_pkg SHALL hold:
- the state enum (IDLE/BUSY/DONE);
- a function computing NCHUNK and its counter width ($clog2, minimum 1).
REQ-032 The package SHALL also hold an elaboration check rejecting WIDTH % CHUNK != 0.
REQ-033 One sub-module chunk_adder (parameter CHUNK, combinational ripple of one_bit_adder cells) SHALL provide:
- the sum slice;
- the carry-out;
- the carry into the chunk MSB, used for ovf.
REQ-034 Exactly one chunk_adder instance SHALL be used, with time-multiplexed chunk selection.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-035 a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0; out_valid exactly 4 cycles after the handshake.
REQ-036 a=0x7FFF, b=0x0001, add -> s=0x8000, cout=0, ovf=1.
REQ-037 a=0x0005, b=0x0007, sub=1, cin=0 -> s=0xFFFE, cout=0, ovf=0; same with cin=1 -> s=0xFFFD.
REQ-038 Backpressure and back-to-back:
- hold out_ready=0 for 3 cycles in DONE -> s stable, in_ready=0;
- then out_ready=1 with in_valid=1 (0x1234+0x1111) -> next result 0x2345 4 cycles later.
REQ-039 rst=1 on the 2nd BUSY cycle -> out_valid stays 0; in_ready=1 the cycle after rst deasserts.
REQ-040 WIDTH=8, CHUNK=8, a=0x80, b=0x80 -> latency 1, s=0x00, cout=1, ovf=1.
